// File: rtl/eth_rx_pkg.sv
// Shared definitions for the MII receive framer: FSM encoding, nibble codes, CRC-32 constants.
// CRC constants are only consumed when the design is built with CRC_CHECK_EN.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_e;

  localparam logic [3:0]  PRE_NIB     = 4'h5;
  localparam logic [3:0]  SFD_NIB     = 4'hD;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 (LSB-first), synchronous clear and enable.
// The register is kept in reflected bit order; callers bit-reverse before comparing residues.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] POLY_REFL = bitrev32(CRC_POLY);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < 8; i++) begin
      crc_d = (crc_d >> 1) ^ ((crc_d[0] ^ data_i[i]) ? POLY_REFL : 32'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      crc_q <= CRC_INIT;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, pairs nibbles into bytes, reports frame status/counters.
// Optional FCS checking is compiled in with the CRC_CHECK_EN macro.
module mii_rx_framer
  import eth_rx_pkg::*;
#(
  parameter int MIN_PRE = 2,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       rxd,
  input  logic             rx_dv,
  input  logic             rx_er,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  output logic             byte_sof,
  output logic             frame_end,
  output logic             frame_ok,
  output logic [LEN_W-1:0] frame_len,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int               PRE_W     = 8;
  localparam logic [PRE_W-1:0] MIN_PRE_L = PRE_W'(MIN_PRE);
  localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  rx_state_e        state_q;
  logic [PRE_W-1:0] pre_cnt_q;
  logic             phase_q;
  logic [3:0]       low_q;
  logic [LEN_W-1:0] len_q;
  logic             bad_q;
  logic             in_frame_q;

  logic [7:0]       byte_data_q;
  logic             byte_valid_q;
  logic             byte_sof_q;
  logic             frame_end_q;
  logic             frame_ok_q;
  logic [LEN_W-1:0] frame_len_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_d;

  logic crc_ok;
  logic pre_abort;
  logic end_now;
  logic good_now;
  logic byte_now;

  // Byte number MAX_LEN+1 is swallowed and pushes the frame into DROP instead.
  assign byte_now = (state_q == ST_DATA) && rx_dv && phase_q && (len_q != MAX_LEN_L);

`ifdef CRC_CHECK_EN
  logic [31:0] crc_val;

  crc32_d8 u_crc (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q != ST_DATA),
    .en_i   (byte_now),
    .data_i ({rxd, low_q}),
    .crc_o  (crc_val)
  );

  assign crc_ok = (bitrev32(crc_val) == CRC_RESIDUE);
`else
  assign crc_ok = 1'b1;
`endif

  assign pre_abort = rx_dv &&
                     (((state_q == ST_IDLE) && (rxd != PRE_NIB)) ||
                      ((state_q == ST_PRE) && (rxd != PRE_NIB) &&
                       !((rxd == SFD_NIB) && (pre_cnt_q >= MIN_PRE_L))));

  assign end_now  = !rx_dv && ((state_q == ST_DATA) || ((state_q == ST_DROP) && in_frame_q));
  assign good_now = end_now && (state_q == ST_DATA) && !bad_q && !phase_q &&
                    (len_q >= MIN_LEN_L) && crc_ok;

  // Aborts and frame ends are mutually exclusive, so at most one error bump per cycle.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (good_now && (frame_cnt_q != '1)) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
    if ((pre_abort || (end_now && !good_now)) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_DROP;
      pre_cnt_q    <= '0;
      phase_q      <= 1'b0;
      low_q        <= '0;
      len_q        <= '0;
      bad_q        <= 1'b0;
      in_frame_q   <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      byte_sof_q   <= 1'b0;
      frame_end_q  <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_len_q  <= '0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      byte_valid_q <= 1'b0;
      byte_sof_q   <= 1'b0;
      frame_end_q  <= 1'b0;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;

      if (end_now) begin
        frame_end_q <= 1'b1;
        frame_ok_q  <= good_now;
        frame_len_q <= len_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (rx_dv) begin
            if (rxd == PRE_NIB) begin
              state_q   <= ST_PRE;
              pre_cnt_q <= PRE_W'(1);
            end else begin
              state_q    <= ST_DROP;
              in_frame_q <= 1'b0;
            end
          end
        end
        ST_PRE: begin
          if (!rx_dv) begin
            state_q <= ST_IDLE;
          end else if (rxd == PRE_NIB) begin
            if (pre_cnt_q != '1) begin
              pre_cnt_q <= pre_cnt_q + 1'b1;
            end
          end else if (!pre_abort) begin
            state_q <= ST_DATA;
            phase_q <= 1'b0;
            len_q   <= '0;
            bad_q   <= 1'b0;
          end else begin
            state_q    <= ST_DROP;
            in_frame_q <= 1'b0;
          end
        end
        ST_DATA: begin
          if (!rx_dv) begin
            state_q <= ST_IDLE;
          end else begin
            if (rx_er) begin
              bad_q <= 1'b1;
            end
            if (!phase_q) begin
              low_q   <= rxd;
              phase_q <= 1'b1;
            end else if (len_q == MAX_LEN_L) begin
              state_q    <= ST_DROP;
              in_frame_q <= 1'b1;
              bad_q      <= 1'b1;
              phase_q    <= 1'b0;
            end else begin
              byte_data_q  <= {rxd, low_q};
              byte_valid_q <= 1'b1;
              byte_sof_q   <= (len_q == '0);
              len_q        <= len_q + 1'b1;
              phase_q      <= 1'b0;
            end
          end
        end
        default: begin
          if (!rx_dv) begin
            state_q    <= ST_IDLE;
            in_frame_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign byte_sof   = byte_sof_q;
  assign frame_end  = frame_end_q;
  assign frame_ok   = frame_ok_q;
  assign frame_len  = frame_len_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule
